// File: rtl/bus_master_interface_if.sv
// Purpose: client-side request/response handshake of the system bus master.
// The client (load/store unit or DMA) drives a request and receives a single
// response pulse per accepted request.
//   req_valid/req_ready   request handshake, accepted on valid & ready at posedge
//   req_write             1 = write, 0 = read
//   req_addr/req_wdata    byte address and write data
//   req_mask              byte-lane mask
//   resp_valid            one-cycle completion pulse
//   resp_rdata            read data, held until the next response
//   resp_error            1 = access timed out, qualified by resp_valid
interface bus_master_interface_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_mask,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_mask,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/bus_master_interface.sv
// Purpose: initiator side of the system bus. Takes one client request at a
// time, drives the bus strobes, waits for the responder's function-complete
// (or a timeout) and returns read data / error status to the client.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   client            request/response handshake (master modport)
//   o_addr_bus        bus address
//   io_data_bus       write data during write accesses, read data otherwise
//   o_rd_bus          read strobe
//   o_wr_bus          write strobe
//   o_data_mask_bus   byte-lane mask
//   i_fc_bus          function complete from the responder (may float)
//
// state   | meaning
// IDLE    | req_ready high, waiting for a client request
// ACCESS  | one strobe high, waiting for fc_bus or timeout
// RELEASE | strobes low for one cycle, resp_valid pulses
module bus_master_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    bus_master_interface_if.master client,
    output logic [31:0]            o_addr_bus,
    inout  wire  [31:0]            io_data_bus,
    output logic                   o_rd_bus,
    output logic                   o_wr_bus,
    output logic [3:0]             o_data_mask_bus,
    input  logic                   i_fc_bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RELEASE
    } state_t;

    // Terminal count for the access timer; a TIMEOUT_CYCLES of 0 disables it.
    localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam bit                   LP_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t                r_state;
    logic                  r_write;
    logic [31:0]           r_wdata;
    logic                  r_data_oe;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [31:0]           r_addr_bus;
    logic [3:0]            r_mask_bus;
    logic                  r_rd_bus;
    logic                  r_wr_bus;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;
    logic                  r_resp_error;

    logic                  w_fc_done;
    logic                  w_timeout;

    // A floating or unknown fc_bus from an unselected responder must not
    // complete the access, so only a clean 1 counts.
    assign w_fc_done = (i_fc_bus === 1'b1);
    assign w_timeout = LP_TIMEOUT_EN && (r_cnt == LP_CNT_LAST);

    assign io_data_bus       = r_data_oe ? r_wdata : 'z;
    assign o_addr_bus        = r_addr_bus;
    assign o_data_mask_bus   = r_mask_bus;
    assign o_rd_bus          = r_rd_bus;
    assign o_wr_bus          = r_wr_bus;

    assign client.req_ready  = (r_state == ST_IDLE);
    assign client.resp_valid = r_resp_valid;
    assign client.resp_rdata = r_resp_rdata;
    assign client.resp_error = r_resp_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_data_oe    <= 1'b0;
            r_cnt        <= '0;
            r_addr_bus   <= '0;
            r_mask_bus   <= '0;
            r_rd_bus     <= 1'b0;
            r_wr_bus     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (client.req_valid) begin
                        r_write    <= client.req_write;
                        r_wdata    <= client.req_wdata;
                        r_addr_bus <= client.req_addr;
                        r_mask_bus <= client.req_mask;
                        r_rd_bus   <= ~client.req_write;
                        r_wr_bus   <= client.req_write;
                        r_data_oe  <= client.req_write;
                        r_cnt      <= '0;
                        r_state    <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    // fc_bus is checked first so a completion on the
                    // terminal-count edge still succeeds.
                    if (w_fc_done) begin
                        if (!r_write) begin
                            r_resp_rdata <= io_data_bus;
                        end
                        r_resp_error <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_rd_bus     <= 1'b0;
                        r_wr_bus     <= 1'b0;
                        r_data_oe    <= 1'b0;
                        r_state      <= ST_RELEASE;
                    end else if (w_timeout) begin
                        r_resp_rdata <= '0;
                        r_resp_error <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_rd_bus     <= 1'b0;
                        r_wr_bus     <= 1'b0;
                        r_data_oe    <= 1'b0;
                        r_state      <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end

                // Strobes stay low here so the responder can clear its
                // write-done flag before the next access can start.
                ST_RELEASE: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
